// File: rtl/vip_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vip_pkg
// Description : Shared types and constants for the Avalon-ST video packet
//               decoder: one-hot state encoding, packet type codes and
//               control-header geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package vip_pkg;

    // One-hot decoder states
    typedef enum logic [4:0] {
        ST_IDLE = 5'b00001,
        ST_CTRL = 5'b00010,
        ST_DATA = 5'b00100,
        ST_USER = 5'b01000,
        ST_DROP = 5'b10000
    } state_e;

    localparam logic [3:0] PKT_VIDEO    = 4'h0;
    localparam logic [3:0] PKT_CTRL     = 4'hF;
    localparam int         CTRL_NIBBLES = 9;

    // Number of payload beats needed to carry a full control header
    function automatic int ctrl_beats(input int planes);
        return (CTRL_NIBBLES + planes - 1) / planes;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vip_reg_slice.sv
`default_nettype none
// ============================================================================
// Module      : vip_reg_slice
// Description : Single-entry valid/ready register stage carrying data, SOP
//               and EOP. The caller loads it only when free_o is high; it
//               empties on ready_i when nothing loads, so a load and an
//               unload in the same cycle sustain full throughput.
// Revision    : 1.0 - initial release
// ============================================================================
module vip_reg_slice #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             sop_i,
    input  logic             eop_i,
    output logic             free_o,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             sop_o,
    output logic             eop_o,
    input  logic             ready_i
);

    logic [WIDTH-1:0] data_q;
    logic             valid_q;
    logic             sop_q;
    logic             eop_q;

    assign free_o  = !valid_q || ready_i;
    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign sop_o   = sop_q;
    assign eop_o   = eop_q;

    // Load a new beat, otherwise drop the held beat once it is taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
        end else if (load_i) begin
            data_q  <= data_i;
            valid_q <= 1'b1;
            sop_q   <= sop_i;
            eop_q   <= eop_i;
        end else if (ready_i) begin
            valid_q <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/vip_packet_decode.sv
`default_nettype none
// ============================================================================
// Module      : vip_packet_decode
// Description : Avalon-ST video packet decoder. Parses control packets into
//               width/height/interlace (committed only on a complete header),
//               strips the type beat from video packets, optionally forwards
//               user packets, and checks each frame's pixel count against
//               the committed geometry.
//               Optional build macro VIP_DECODE_STATS_EN adds the frame_cnt
//               and err_cnt statistics outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module vip_packet_decode
    import vip_pkg::*;
#(
    parameter int COLOR_BITS   = 8,
    parameter int COLOR_PLANES = 3,
    parameter int DATA_WIDTH   = COLOR_BITS * COLOR_PLANES,
    parameter int PASS_USER    = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] din_data,
    input  logic                  din_valid,
    input  logic                  din_startofpacket,
    input  logic                  din_endofpacket,
    output logic                  din_ready,
    output logic [DATA_WIDTH-1:0] dout_data,
    output logic                  dout_valid,
    output logic                  dout_startofpacket,
    output logic                  dout_endofpacket,
    input  logic                  dout_ready,
    output logic [15:0]           im_width,
    output logic [15:0]           im_height,
    output logic [3:0]            im_interlaced,
    output logic                  ctrl_update,
    output logic                  ctrl_err,
    output logic                  frame_done,
    output logic                  frame_short,
    output logic                  frame_long,
`ifdef VIP_DECODE_STATS_EN
    output logic [15:0]           frame_cnt,
    output logic [15:0]           err_cnt,
`endif
    output logic                  sop_err
);

    localparam int SHADOW_W = 4 * CTRL_NIBBLES;

    state_e                state_q, state_d;
    logic [SHADOW_W-1:0]   shadow_q, shadow_d, w_shadow_cap;
    logic [3:0]            nib_cnt_q, nib_cnt_d, w_cnt_cap;
    logic [4:0]            w_cnt_sum;
    logic [15:0]           width_q, width_d;
    logic [15:0]           height_q, height_d;
    logic [3:0]            ilace_q, ilace_d;
    logic [31:0]           pix_q, pix_d, w_pix_inc, w_area;
    logic                  first_q, first_d;
    logic                  upd_q, upd_d;
    logic                  cerr_q, cerr_d;
    logic                  done_q, done_d;
    logic                  short_q, short_d;
    logic                  long_q, long_d;
    logic                  serr_q, serr_d;
    logic                  w_acc;
    logic                  w_slice_free;
    logic                  w_load;
    logic                  w_ld_sop;
    logic [3:0]            w_type;

    assign w_acc     = din_valid && din_ready;
    assign w_type    = din_data[3:0];
    assign w_area    = {16'd0, width_q} * {16'd0, height_q};
    assign w_pix_inc = (&pix_q) ? pix_q : pix_q + 32'd1;
    assign w_cnt_sum = {1'b0, nib_cnt_q} + 5'(COLOR_PLANES);
    assign w_cnt_cap = (w_cnt_sum >= 5'(CTRL_NIBBLES)) ? 4'(CTRL_NIBBLES) : w_cnt_sum[3:0];

    // With user pass-through a type beat can be forwarded straight from
    // IDLE/CTRL/DROP, so those states must also wait for a free output stage.
    always_comb begin
        if (PASS_USER != 0 || state_q == ST_DATA || state_q == ST_USER) begin
            din_ready = w_slice_free;
        end else begin
            din_ready = 1'b1;
        end
    end

    // Merge this beat's nibbles into the shadow header; highest plane first
    always_comb begin
        w_shadow_cap = shadow_q;
        for (int p = 0; p < COLOR_PLANES; p++) begin
            if ((int'(nib_cnt_q) + COLOR_PLANES - 1 - p) < CTRL_NIBBLES) begin
                w_shadow_cap[SHADOW_W - 4 - 4 * (int'(nib_cnt_q) + COLOR_PLANES - 1 - p) +: 4]
                    = din_data[p * COLOR_BITS +: 4];
            end
        end
    end

    // Packet decode: next state, header/pixel bookkeeping and event pulses
    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        nib_cnt_d = nib_cnt_q;
        width_d   = width_q;
        height_d  = height_q;
        ilace_d   = ilace_q;
        pix_d     = pix_q;
        first_d   = first_q;
        upd_d     = 1'b0;
        cerr_d    = 1'b0;
        done_d    = 1'b0;
        short_d   = 1'b0;
        long_d    = 1'b0;
        serr_d    = 1'b0;
        w_load    = 1'b0;
        w_ld_sop  = 1'b0;

        if (w_acc) begin
            if (din_startofpacket) begin
                // Any SOP starts a fresh packet; a packet in flight is abandoned
                serr_d    = (state_q != ST_IDLE);
                shadow_d  = '0;
                nib_cnt_d = 4'd0;
                pix_d     = 32'd0;
                first_d   = 1'b1;
                case (w_type)
                    PKT_VIDEO: begin
                        if (din_endofpacket) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                            short_d = (w_area != 32'd0);
                        end else begin
                            state_d = ST_DATA;
                        end
                    end
                    PKT_CTRL: begin
                        if (din_endofpacket) begin
                            state_d = ST_IDLE;
                            cerr_d  = 1'b1;
                        end else begin
                            state_d = ST_CTRL;
                        end
                    end
                    default: begin
                        if (PASS_USER != 0) begin
                            w_load   = 1'b1;
                            w_ld_sop = 1'b1;
                            state_d  = din_endofpacket ? ST_IDLE : ST_USER;
                        end else begin
                            state_d  = din_endofpacket ? ST_IDLE : ST_DROP;
                        end
                    end
                endcase
            end else begin
                case (state_q)
                    ST_CTRL: begin
                        shadow_d  = w_shadow_cap;
                        nib_cnt_d = w_cnt_cap;
                        if (din_endofpacket) begin
                            state_d = ST_IDLE;
                            if (w_cnt_cap == 4'(CTRL_NIBBLES)) begin
                                width_d  = w_shadow_cap[SHADOW_W-1 -: 16];
                                height_d = w_shadow_cap[SHADOW_W-17 -: 16];
                                ilace_d  = w_shadow_cap[3:0];
                                upd_d    = 1'b1;
                            end else begin
                                cerr_d   = 1'b1;
                            end
                        end
                    end
                    ST_DATA: begin
                        w_load   = 1'b1;
                        w_ld_sop = first_q;
                        first_d  = 1'b0;
                        pix_d    = w_pix_inc;
                        if (din_endofpacket) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                            if (w_area != 32'd0) begin
                                short_d = (w_pix_inc < w_area);
                                long_d  = (w_pix_inc > w_area);
                            end
                        end
                    end
                    ST_USER: begin
                        w_load = 1'b1;
                        if (din_endofpacket) state_d = ST_IDLE;
                    end
                    ST_DROP: begin
                        if (din_endofpacket) state_d = ST_IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Decoder state and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            shadow_q  <= '0;
            nib_cnt_q <= 4'd0;
            width_q   <= 16'd0;
            height_q  <= 16'd0;
            ilace_q   <= 4'd0;
            pix_q     <= 32'd0;
            first_q   <= 1'b0;
            upd_q     <= 1'b0;
            cerr_q    <= 1'b0;
            done_q    <= 1'b0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            serr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            nib_cnt_q <= nib_cnt_d;
            width_q   <= width_d;
            height_q  <= height_d;
            ilace_q   <= ilace_d;
            pix_q     <= pix_d;
            first_q   <= first_d;
            upd_q     <= upd_d;
            cerr_q    <= cerr_d;
            done_q    <= done_d;
            short_q   <= short_d;
            long_q    <= long_d;
            serr_q    <= serr_d;
        end
    end

    vip_reg_slice #(
        .WIDTH (DATA_WIDTH)
    ) u_slice (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (w_load),
        .data_i  (din_data),
        .sop_i   (w_ld_sop),
        .eop_i   (din_endofpacket),
        .free_o  (w_slice_free),
        .data_o  (dout_data),
        .valid_o (dout_valid),
        .sop_o   (dout_startofpacket),
        .eop_o   (dout_endofpacket),
        .ready_i (dout_ready)
    );

    assign im_width      = width_q;
    assign im_height     = height_q;
    assign im_interlaced = ilace_q;
    assign ctrl_update   = upd_q;
    assign ctrl_err      = cerr_q;
    assign frame_done    = done_q;
    assign frame_short   = short_q;
    assign frame_long    = long_q;
    assign sop_err       = serr_q;

`ifdef VIP_DECODE_STATS_EN
    logic [15:0] frame_cnt_q;
    logic [15:0] err_cnt_q;
    logic [2:0]  w_err_events;

    // Several error events can coincide (e.g. SOP abort plus a short frame)
    assign w_err_events = 3'(cerr_d) + 3'(short_d) + 3'(long_d) + 3'(serr_d);

    // Wrapping statistics counters, updated together with the event pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= 16'd0;
            err_cnt_q   <= 16'd0;
        end else begin
            frame_cnt_q <= frame_cnt_q + 16'(done_d);
            err_cnt_q   <= err_cnt_q + 16'(w_err_events);
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vip_packet_decode.sv
`default_nettype none
// ============================================================================
// Module      : tb_vip_packet_decode
// Description : Self-checking bench. Instance A: 3 planes, user packets
//               dropped. Instance B: 1 plane, user packets forwarded. A
//               select bit routes stimulus and observation to one instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vip_packet_decode;

    typedef struct packed {
        logic [23:0] d;
        logic        s;
        logic        e;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] din_data;
    logic        din_valid, din_sop, din_eop;
    logic        dout_ready = 1'b1;
    logic        sel;
    logic [23:0] mask;
    bit          gaps;
    int          rdy_mode;
    int          n_checks = 0;
    int          n_fail = 0;

    // Reference model state: committed geometry as the bench understands it
    int          mw, mh;

    always #5 clk = ~clk;

    logic        a_ready, a_ov, a_os, a_oe, a_upd, a_cerr, a_done, a_short, a_long, a_serr;
    logic [23:0] a_od;
    logic [15:0] a_w, a_h;
    logic [3:0]  a_il;
    logic        b_ready, b_ov, b_os, b_oe, b_upd, b_cerr, b_done, b_short, b_long, b_serr;
    logic [7:0]  b_od;
    logic [15:0] b_w, b_h;
    logic [3:0]  b_il;
`ifdef VIP_DECODE_STATS_EN
    logic [15:0] a_fc, a_ec, b_fc, b_ec;
`endif

    vip_packet_decode #(.COLOR_BITS(8), .COLOR_PLANES(3), .PASS_USER(0)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .din_data(din_data), .din_valid(din_valid && !sel),
        .din_startofpacket(din_sop), .din_endofpacket(din_eop), .din_ready(a_ready),
        .dout_data(a_od), .dout_valid(a_ov), .dout_startofpacket(a_os),
        .dout_endofpacket(a_oe), .dout_ready(dout_ready),
        .im_width(a_w), .im_height(a_h), .im_interlaced(a_il),
        .ctrl_update(a_upd), .ctrl_err(a_cerr), .frame_done(a_done),
        .frame_short(a_short), .frame_long(a_long),
`ifdef VIP_DECODE_STATS_EN
        .frame_cnt(a_fc), .err_cnt(a_ec),
`endif
        .sop_err(a_serr)
    );

    vip_packet_decode #(.COLOR_BITS(8), .COLOR_PLANES(1), .PASS_USER(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .din_data(din_data[7:0]), .din_valid(din_valid && sel),
        .din_startofpacket(din_sop), .din_endofpacket(din_eop), .din_ready(b_ready),
        .dout_data(b_od), .dout_valid(b_ov), .dout_startofpacket(b_os),
        .dout_endofpacket(b_oe), .dout_ready(dout_ready),
        .im_width(b_w), .im_height(b_h), .im_interlaced(b_il),
        .ctrl_update(b_upd), .ctrl_err(b_cerr), .frame_done(b_done),
        .frame_short(b_short), .frame_long(b_long),
`ifdef VIP_DECODE_STATS_EN
        .frame_cnt(b_fc), .err_cnt(b_ec),
`endif
        .sop_err(b_serr)
    );

    logic        w_ready, o_valid, o_sop, o_eop, o_upd, o_cerr, o_done, o_short, o_long, o_serr;
    logic [23:0] o_data;
    logic [15:0] o_w, o_h;
    logic [3:0]  o_il;

    assign w_ready = sel ? b_ready : a_ready;
    assign o_valid = sel ? b_ov    : a_ov;
    assign o_sop   = sel ? b_os    : a_os;
    assign o_eop   = sel ? b_oe    : a_oe;
    assign o_data  = sel ? {16'd0, b_od} : a_od;
    assign o_w     = sel ? b_w     : a_w;
    assign o_h     = sel ? b_h     : a_h;
    assign o_il    = sel ? b_il    : a_il;
    assign o_upd   = sel ? b_upd   : a_upd;
    assign o_cerr  = sel ? b_cerr  : a_cerr;
    assign o_done  = sel ? b_done  : a_done;
    assign o_short = sel ? b_short : a_short;
    assign o_long  = sel ? b_long  : a_long;
    assign o_serr  = sel ? b_serr  : a_serr;

    // Observation: output handshakes and event pulses of the selected instance
    beat_t outq[$];
    beat_t expq[$];
    int    n_upd, n_cerr, n_done, n_short, n_long, n_serr, n_notready;

    always @(negedge clk) begin
        if (rst_n) begin
            if (o_valid && dout_ready) outq.push_back({o_data, o_sop, o_eop});
            if (o_upd)   n_upd++;
            if (o_cerr)  n_cerr++;
            if (o_done)  n_done++;
            if (o_short) n_short++;
            if (o_long)  n_long++;
            if (o_serr)  n_serr++;
            if (!w_ready) n_notready++;
        end
    end

    // Downstream back-pressure: always ready or 50% random
    initial begin
        forever begin
            @(posedge clk);
            #1;
            dout_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    task automatic clear_obs();
        outq.delete();
        expq.delete();
        n_upd = 0; n_cerr = 0; n_done = 0; n_short = 0;
        n_long = 0; n_serr = 0; n_notready = 0;
    endtask

    task automatic drain();
        din_valid = 1'b0;
        repeat (40) @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until accepted (bounded wait)
    task automatic send(input logic [23:0] d, input logic s, input logic e);
        int waits = 0;
        din_data = d; din_sop = s; din_eop = e; din_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (w_ready) break;
            waits++;
            if (waits > 500) begin
                n_checks++; n_fail++;
                $display("FAIL send_timeout: din_ready stuck at %0b, required 1", w_ready);
                break;
            end
        end
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        if (gaps && $urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 2)) @(posedge clk);
            #1;
        end
    endtask

    // Control packet: header nibbles MSB-first, highest plane carries the first
    task automatic send_ctrl(input int planes, input logic [15:0] w, input logic [15:0] h,
                             input logic [3:0] il, input int nbeats);
        logic [3:0]  nib[9];
        logic [23:0] d;
        for (int n = 0; n < 4; n++) begin
            nib[n]     = 4'((w >> (12 - 4 * n)) & 16'hF);
            nib[4 + n] = 4'((h >> (12 - 4 * n)) & 16'hF);
        end
        nib[8] = il;
        d = 24'($urandom) & mask;
        d[3:0] = 4'hF;
        send(d, 1'b1, 1'b0);
        for (int k = 0; k < nbeats; k++) begin
            d = 24'($urandom) & mask;
            for (int p = 0; p < planes; p++) begin
                if (k * planes + planes - 1 - p < 9) d[p * 8 +: 4] = nib[k * planes + planes - 1 - p];
            end
            send(d, 1'b0, k == nbeats - 1);
        end
    endtask

    // Video packet: type beat then npix pixels; expected output = the pixels
    task automatic send_video(input int npix, input bit with_eop);
        logic [23:0] d;
        d = 24'($urandom) & mask;
        d[3:0] = 4'h0;
        send(d, 1'b1, with_eop && npix == 0);
        for (int i = 0; i < npix; i++) begin
            d = 24'($urandom) & mask;
            send(d, 1'b0, with_eop && i == npix - 1);
            expq.push_back({d, i == 0, with_eop && i == npix - 1});
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if ({a_ov, b_ov} !== 2'b00) begin n_fail++; $display("FAIL reset_valid: got %b required 00", {a_ov, b_ov}); end
        n_checks++; if ({a_w, a_h, a_il} !== 36'd0) begin n_fail++; $display("FAIL reset_geom_a: got %h required 0", {a_w, a_h, a_il}); end
        n_checks++; if ({b_w, b_h, b_il} !== 36'd0) begin n_fail++; $display("FAIL reset_geom_b: got %h required 0", {b_w, b_h, b_il}); end
        n_checks++; if ({a_upd, a_cerr, a_done, a_short, a_long, a_serr} !== 6'd0) begin
            n_fail++; $display("FAIL reset_pulses: got %b required 000000", {a_upd, a_cerr, a_done, a_short, a_long, a_serr});
        end
        n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b required 1", a_ready); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_ctrl_p1();
        clear_obs(); gaps = 0; rdy_mode = 0;
        send_ctrl(1, 16'h0280, 16'h01E0, 4'h0, 9);
        mw = 16'h0280; mh = 16'h01E0;
        n_checks++; if (o_upd !== 1'b1) begin n_fail++; $display("FAIL p1_update: got %b required 1", o_upd); end
        n_checks++; if (o_w !== 16'h0280) begin n_fail++; $display("FAIL p1_width: got %h required 0280", o_w); end
        n_checks++; if (o_h !== 16'h01E0) begin n_fail++; $display("FAIL p1_height: got %h required 01e0", o_h); end
        n_checks++; if (o_il !== 4'h0) begin n_fail++; $display("FAIL p1_ilace: got %h required 0", o_il); end
        @(posedge clk);
        #1;
        n_checks++; if (o_upd !== 1'b0) begin n_fail++; $display("FAIL p1_update_width: got %b required 0", o_upd); end
    endtask

    task automatic test_user_pass();
        logic [23:0] d;
        int nbad = 0;
        clear_obs(); gaps = 1; rdy_mode = 1;
        for (int i = 0; i < 10; i++) begin
            d = 24'($urandom) & mask;
            if (i == 0) d[3:0] = 4'h5;
            send(d, i == 0, i == 9);
            expq.push_back({d, i == 0, i == 9});
        end
        drain();
        n_checks++; if (outq.size() != expq.size()) begin n_fail++; $display("FAIL user_pass_count: got %0d required %0d", outq.size(), expq.size()); end
        foreach (expq[i]) if (i >= outq.size() || outq[i] !== expq[i]) nbad++;
        n_checks++; if (nbad != 0) begin n_fail++; $display("FAIL user_pass_data: %0d beats differ, required 0", nbad); end
    endtask

    task automatic test_zero_area();
        int nbad = 0;
        clear_obs(); gaps = 0; rdy_mode = 0;
        send_ctrl(1, 16'h0000, 16'h01E0, 4'hA, 9);
        mw = 0; mh = 16'h01E0;
        n_checks++; if ({o_w, o_h, o_il} !== {16'h0000, 16'h01E0, 4'hA}) begin
            n_fail++; $display("FAIL zero_geom: got %h required 000001e0a", {o_w, o_h, o_il});
        end
        gaps = 1; rdy_mode = 1;
        send_video(5, 1'b1);
        drain();
        n_checks++; if ({n_done, n_short, n_long} !== {32'd1, 32'd0, 32'd0}) begin
            n_fail++; $display("FAIL zero_flags: got done=%0d short=%0d long=%0d required 1 0 0", n_done, n_short, n_long);
        end
        foreach (expq[i]) if (i >= outq.size() || outq[i] !== expq[i]) nbad++;
        n_checks++; if (nbad != 0 || outq.size() != 5) begin n_fail++; $display("FAIL zero_data: %0d bad of %0d beats, required 0 of 5", nbad, outq.size()); end
    endtask

    task automatic test_ctrl_p3();
        clear_obs(); gaps = 0; rdy_mode = 0;
        send_ctrl(3, 16'h0010, 16'h0004, 4'h3, 3);
        mw = 16'h0010; mh = 16'h0004;
        n_checks++; if (o_upd !== 1'b1) begin n_fail++; $display("FAIL p3_update: got %b required 1", o_upd); end
        n_checks++; if ({o_w, o_h, o_il} !== {16'h0010, 16'h0004, 4'h3}) begin
            n_fail++; $display("FAIL p3_geom: got %h required 0010_0004_3", {o_w, o_h, o_il});
        end
    endtask

    task automatic test_video_frames();
        int lens[3] = '{64, 63, 65};
        for (int t = 0; t < 3; t++) begin
            int nbad = 0;
            clear_obs();
            rdy_mode = (t == 0) ? 0 : 1;
            gaps = (t != 0);
            send_video(lens[t], 1'b1);
            drain();
            n_checks++; if (outq.size() != lens[t]) begin n_fail++; $display("FAIL frame%0d_count: got %0d required %0d", t, outq.size(), lens[t]); end
            foreach (expq[i]) if (i >= outq.size() || outq[i] !== expq[i]) nbad++;
            n_checks++; if (nbad != 0) begin n_fail++; $display("FAIL frame%0d_data: %0d beats differ, required 0", t, nbad); end
            n_checks++; if (n_done != 1) begin n_fail++; $display("FAIL frame%0d_done: got %0d required 1", t, n_done); end
            n_checks++; if (n_short != int'(lens[t] < mw * mh) || n_long != int'(lens[t] > mw * mh)) begin
                n_fail++; $display("FAIL frame%0d_flags: got short=%0d long=%0d required %0d %0d",
                                   t, n_short, n_long, int'(lens[t] < mw * mh), int'(lens[t] > mw * mh));
            end
        end
    endtask

    task automatic test_ctrl_err();
        clear_obs(); gaps = 0; rdy_mode = 0;
        send_ctrl(3, 16'h1234, 16'h5678, 4'h1, 2);
        n_checks++; if (o_cerr !== 1'b1) begin n_fail++; $display("FAIL cerr_pulse: got %b required 1", o_cerr); end
        n_checks++; if ({o_w, o_h} !== {16'h0010, 16'h0004}) begin n_fail++; $display("FAIL cerr_keep: got %h required 00100004", {o_w, o_h}); end
        drain();
        n_checks++; if (n_upd != 0 || n_cerr != 1) begin n_fail++; $display("FAIL cerr_counts: got upd=%0d err=%0d required 0 1", n_upd, n_cerr); end
    endtask

    task automatic test_single_beats();
        logic [23:0] d;
        clear_obs(); gaps = 0; rdy_mode = 0;
        d = 24'($urandom) & mask; d[3:0] = 4'hF;
        send(d, 1'b1, 1'b1);
        n_checks++; if (o_cerr !== 1'b1) begin n_fail++; $display("FAIL single_ctrl_err: got %b required 1", o_cerr); end
        d = 24'($urandom) & mask; d[3:0] = 4'h0;
        send(d, 1'b1, 1'b1);
        n_checks++; if ({o_done, o_short, o_long} !== {1'b1, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL single_video_flags: got %b required 110", {o_done, o_short, o_long});
        end
        drain();
        n_checks++; if (outq.size() != 0) begin n_fail++; $display("FAIL single_no_output: got %0d beats required 0", outq.size()); end
    endtask

    task automatic test_sop_restart();
        int nbad = 0;
        clear_obs(); gaps = 1; rdy_mode = 1;
        send_video(10, 1'b0);
        send_video(64, 1'b1);
        drain();
        n_checks++; if (n_serr != 1) begin n_fail++; $display("FAIL restart_soperr: got %0d required 1", n_serr); end
        n_checks++; if ({n_done, n_short, n_long} !== {32'd1, 32'd0, 32'd0}) begin
            n_fail++; $display("FAIL restart_flags: got done=%0d short=%0d long=%0d required 1 0 0", n_done, n_short, n_long);
        end
        foreach (expq[i]) if (i >= outq.size() || outq[i] !== expq[i]) nbad++;
        n_checks++; if (nbad != 0 || outq.size() != 74) begin n_fail++; $display("FAIL restart_data: %0d bad of %0d beats, required 0 of 74", nbad, outq.size()); end
    endtask

    task automatic test_user_drop();
        logic [23:0] d;
        clear_obs(); gaps = 1; rdy_mode = 1;
        send(24'($urandom) & mask, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            d = 24'($urandom) & mask;
            if (i == 0) d[3:0] = 4'h5;
            send(d, i == 0, i == 9);
        end
        drain();
        n_checks++; if (outq.size() != 0) begin n_fail++; $display("FAIL drop_output: got %0d beats required 0", outq.size()); end
        n_checks++; if (n_notready != 0) begin n_fail++; $display("FAIL drop_ready: low for %0d cycles required 0", n_notready); end
        n_checks++; if (n_serr != 0 || n_done != 0) begin n_fail++; $display("FAIL drop_events: got soperr=%0d done=%0d required 0 0", n_serr, n_done); end
        send_video(64, 1'b1);
        drain();
        n_checks++; if (outq.size() != 64 || n_done != 1 || n_short != 0) begin
            n_fail++; $display("FAIL drop_recover: got %0d beats done=%0d short=%0d required 64 1 0", outq.size(), n_done, n_short);
        end
    endtask

    initial begin
        din_data = '0; din_valid = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
        sel = 1'b1; mask = 24'h0000FF; gaps = 0; rdy_mode = 0; mw = 0; mh = 0;
        clear_obs();
        test_reset();
        test_ctrl_p1();
        test_user_pass();
        test_zero_area();
        drain();
        sel = 1'b0; mask = 24'hFFFFFF;
        test_ctrl_p3();
        test_video_frames();
        test_ctrl_err();
        test_single_beats();
        test_sop_restart();
        test_user_drop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
